rpu_out_desc_gather: RTL

Gathers descriptors emitted by an RPU on its `out_desc` channel and delivers them to the interconnect scheduler as complete units. Sits directly downstream of the RPU partial-reconfiguration wrapper, on the static side of the PR boundary. A descriptor is either one 64-bit beat or two 64-bit beats. The block merges two-beat descriptors into one 128-bit entry and buffers entries in a small FIFO, so the scheduler never sees half a descriptor.

---
 rtl/rpu_desc_pkg.sv | 19 +
 rtl/rpu_out_desc_gather_if.sv | 30 +++
 rtl/rpu_desc_fifo.sv | 69 ++++++
 rtl/rpu_out_desc_gather.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/rpu_desc_pkg.sv
// Shared types for the RPU out_desc gatherer: beat width, merged FIFO entry and sequencer state.
package rpu_desc_pkg;

    localparam int DESC_WIDTH = 64;

    typedef struct packed {
        logic                  two;
        logic [DESC_WIDTH-1:0] hi;
        logic [DESC_WIDTH-1:0] lo;
    } desc_entry_t;

    localparam int ENTRY_WIDTH = $bits(desc_entry_t);

    typedef enum logic {
        IDLE = 1'b0,
        HEAD = 1'b1
    } gather_state_t;

endpackage

// File: rtl/rpu_out_desc_gather_if.sv
// Beat channel from the RPU and entry channel to the scheduler, bundled for rpu_out_desc_gather.
interface rpu_out_desc_gather_if;
    import rpu_desc_pkg::*;

    logic [DESC_WIDTH-1:0] s_desc;
    logic                  s_desc_2nd;
    logic                  s_desc_valid;
    logic                  s_desc_ready;

    logic [DESC_WIDTH-1:0] m_desc_lo;
    logic [DESC_WIDTH-1:0] m_desc_hi;
    logic                  m_desc_two;
    logic                  m_desc_valid;
    logic                  m_desc_ready;

    modport master (
        output s_desc, s_desc_2nd, s_desc_valid,
        input  s_desc_ready,
        input  m_desc_lo, m_desc_hi, m_desc_two, m_desc_valid,
        output m_desc_ready
    );

    modport slave (
        input  s_desc, s_desc_2nd, s_desc_valid,
        output s_desc_ready,
        output m_desc_lo, m_desc_hi, m_desc_two, m_desc_valid,
        input  m_desc_ready
    );

endinterface

// File: rtl/rpu_desc_fifo.sv
// Generic synchronous first-word-fall-through FIFO; storage is unreset so it maps to distributed RAM.
module rpu_desc_fifo #(
    parameter int WIDTH = 129,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == CW'(0));
    assign count     = count_r;
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Storage write port.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy; power-of-two depth makes the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head of queue, forced to zero when nothing is stored.
    always_comb begin
        if (empty) begin
            pop_data = {WIDTH{1'b0}};
        end else begin
            pop_data = mem_r[rd_ptr_r];
        end
    end

endmodule

// File: rtl/rpu_out_desc_gather.sv
// Merges one/two-beat RPU descriptors into whole FIFO entries for the scheduler.
// Optional statistics counters are built when RPU_DESC_GATHER_STATS_EN is defined.
module rpu_out_desc_gather #(
    parameter int DEPTH      = 16,
    parameter int DESC_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    core_reset,
    rpu_out_desc_gather_if.slave    desc,
    output logic                    err_seq,
    output logic [31:0]             stat_desc_count,
    output logic [31:0]             stat_stall_count
);
    import rpu_desc_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    gather_state_t         state_r;
    logic [DESC_WIDTH-1:0] hold_r;
    logic                  err_r;

    desc_entry_t           push_entry_s;
    desc_entry_t           pop_entry_s;
    logic                  push_s;
    logic                  ready_s;
    logic                  accept_s;
    logic                  full_s;
    logic                  empty_s;
    logic [CW-1:0]         count_s;

    // Space is judged on the registered count alone, so a same-cycle pop never frees a slot early.
    assign ready_s           = (count_s < CW'(DEPTH)) && !core_reset;
    assign accept_s          = desc.s_desc_valid && ready_s;
    assign desc.s_desc_ready = ready_s;

    // Build the entry to push: single beats go straight in, tails merge with the held head.
    always_comb begin
        push_s            = 1'b0;
        push_entry_s.two  = 1'b0;
        push_entry_s.hi   = {DESC_WIDTH{1'b0}};
        push_entry_s.lo   = desc.s_desc;
        case (state_r)
            IDLE: begin
                if (accept_s && !desc.s_desc_2nd && !full_s) begin
                    push_s = 1'b1;
                end else begin
                    push_s = 1'b0;
                end
            end
            HEAD: begin
                if (accept_s && !full_s) begin
                    push_s           = 1'b1;
                    push_entry_s.two = 1'b1;
                    push_entry_s.hi  = desc.s_desc;
                    push_entry_s.lo  = hold_r;
                end else begin
                    push_s = 1'b0;
                end
            end
            default: push_s = 1'b0;
        endcase
    end

    // Sequencer: holds a head beat until its tail arrives; flags tails marked as heads and dropped heads.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            hold_r  <= {DESC_WIDTH{1'b0}};
            err_r   <= 1'b0;
        end else begin
            err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s && desc.s_desc_2nd) begin
                        hold_r  <= desc.s_desc;
                        state_r <= HEAD;
                    end
                end
                HEAD: begin
                    if (core_reset) begin
                        hold_r  <= {DESC_WIDTH{1'b0}};
                        state_r <= IDLE;
                        err_r   <= 1'b1;
                    end else if (accept_s) begin
                        state_r <= IDLE;
                        err_r   <= desc.s_desc_2nd;
                    end
                end
                default: begin
                    hold_r  <= {DESC_WIDTH{1'b0}};
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign err_seq = err_r;

    rpu_desc_fifo #(
        .WIDTH (ENTRY_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (desc.m_desc_ready),
        .pop_data  (pop_entry_s),
        .full      (full_s),
        .empty     (empty_s),
        .count     (count_s)
    );

    assign desc.m_desc_lo    = pop_entry_s.lo;
    assign desc.m_desc_hi    = pop_entry_s.hi;
    assign desc.m_desc_two   = pop_entry_s.two;
    assign desc.m_desc_valid = !empty_s;

`ifdef RPU_DESC_GATHER_STATS_EN
    logic [31:0] desc_cnt_r;
    logic [31:0] stall_cnt_r;

    // Free-running, wrapping statistics; only the block reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            desc_cnt_r  <= 32'd0;
            stall_cnt_r <= 32'd0;
        end else begin
            if (push_s) begin
                desc_cnt_r <= desc_cnt_r + 32'd1;
            end
            if (!empty_s && !desc.m_desc_ready) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end
        end
    end

    assign stat_desc_count  = desc_cnt_r;
    assign stat_stall_count = stall_cnt_r;
`else
    assign stat_desc_count  = 32'd0;
    assign stat_stall_count = 32'd0;
`endif

endmodule
